// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one staging-FIFO write port between NUM_CH stream channels.
// Optional write-acknowledge checking is compiled in with `define WR_ACK_CHECK_EN.
module fifo_wr_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_last,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        grant,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_data_in,
    input  logic                     fifo_full,
    input  logic                     fifo_wr_ack,
    output logic                     busy,
    output logic                     ack_err
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, BURST, RELEASE} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;   // last winner, which is also the current owner
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_valid;
    logic             xfer;
    logic             burst_end;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        cand       = '0;
        // Scan farthest-to-nearest so the nearest requester after rr_ptr overrides.
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
            if (ch_req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        xfer             = (state == BURST) && ch_req[rr_ptr] && !fifo_full;
        burst_end        = xfer && (ch_last[rr_ptr] || (beat_cnt == CNT_W'(MAX_BURST - 1)));
        fifo_wr_en       = xfer;
        ch_ready         = '0;
        ch_ready[rr_ptr] = xfer;
        fifo_data_in     = ch_data[rr_ptr*DATA_W +: DATA_W];
        busy             = (state == GRANT) || (state == BURST);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= IDX_W'(NUM_CH - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        rr_ptr <= pick;
                        grant  <= NUM_CH'(1) << pick;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt <= '0;
                    state    <= BURST;
                end
                BURST: begin
                    if (!ch_req[rr_ptr]) begin
                        grant <= '0;
                        state <= RELEASE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (burst_end) begin
                            grant <= '0;
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_ACK_CHECK_EN
    logic wr_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            wr_en_q <= fifo_wr_en;
            if (wr_en_q != fifo_wr_ack) ack_err <= 1'b1;
        end
    end
`else
    logic unused_wr_ack;
    assign unused_wr_ack = fifo_wr_ack;
    assign ack_err       = 1'b0;
`endif

endmodule
